// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, immediate-select codes,
// the ID/EX control bundle and the decode FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_S = 3'b000;
  localparam logic [2:0] IMM_J = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_I = 3'b100;

  typedef struct packed {
    logic is_load;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
  } ctrl_t;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational opcode decoder: controls, imm_sel, legality and
// which source registers the instruction reads.
module decode_comb
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [4:0] i_rd,
  output ctrl_t      o_ctrl,
  output logic [2:0] o_imm_sel,
  output logic       o_legal,
  output logic       o_use_rs1,
  output logic       o_use_rs2
);

  logic w_wr;

  // Opcode classification; unknown opcodes fall through as illegal bubbles.
  always_comb begin
    o_ctrl    = '0;
    o_imm_sel = IMM_I;
    o_legal   = 1'b1;
    o_use_rs1 = 1'b1;
    o_use_rs2 = 1'b0;
    w_wr      = 1'b0;
    case (i_opcode)
      OP_LOAD:   begin o_ctrl.is_load = 1'b1; w_wr = 1'b1; end
      OP_STORE:  begin o_ctrl.mem_write = 1'b1; o_imm_sel = IMM_S; o_use_rs2 = 1'b1; end
      OP_BRANCH: begin o_ctrl.branch = 1'b1; o_imm_sel = IMM_B; o_use_rs2 = 1'b1; end
      OP_JAL:    begin o_ctrl.jump = 1'b1; o_imm_sel = IMM_J; o_use_rs1 = 1'b0; w_wr = 1'b1; end
      OP_JALR:   begin o_ctrl.jump = 1'b1; w_wr = 1'b1; end
      OP_LUI,
      OP_AUIPC:  begin o_imm_sel = IMM_U; o_use_rs1 = 1'b0; w_wr = 1'b1; end
      OP_IMM:    w_wr = 1'b1;
      OP_OP:     begin o_use_rs2 = 1'b1; w_wr = 1'b1; end
      default:   begin o_legal = 1'b0; o_use_rs1 = 1'b0; end
    endcase
    // Writes to x0 are architecturally discarded, so never flag them.
    o_ctrl.reg_write = w_wr && (i_rd != 5'd0);
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: classifies IF instructions, owns the ID/EX
// slot, inserts load-use bubbles, handles flush and illegal-opcode trap.
module decode_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  input  logic             flush_i,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [2:0]       imm_sel,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic             id_is_load,
  output logic             id_mem_write,
  output logic             id_reg_write,
  output logic             id_branch,
  output logic             id_jump,
  output logic             id_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           r_state, w_next;
  logic             r_valid;
  logic [XLEN-1:0]  r_instr, r_pc;
  logic [2:0]       r_imm;
  logic [4:0]       r_rd, r_rs1, r_rs2;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cnt;

  ctrl_t            w_ctrl;
  logic [2:0]       w_imm;
  logic             w_legal, w_use_rs1, w_use_rs2;
  logic             w_adv, w_hazard, w_if_ready, w_accept, w_load, w_trap;
  logic [4:0]       w_rs1, w_rs2;

  decode_comb u_dec (
    .i_opcode  (if_instr[6:0]),
    .i_rd      (if_instr[11:7]),
    .o_ctrl    (w_ctrl),
    .o_imm_sel (w_imm),
    .o_legal   (w_legal),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_rs1 = if_instr[19:15];
  assign w_rs2 = if_instr[24:20];

  // Hazard only looks at the slot and if_instr; flush_i never reaches if_ready.
  assign w_adv      = !r_valid || ex_ready;
  assign w_hazard   = r_valid && r_ctrl.is_load && (r_rd != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));
  assign w_if_ready = w_adv && !w_hazard && (r_state == RUN);
  // A flush discards whatever IF hands over in the same cycle, illegal or not.
  assign w_accept   = if_valid && w_if_ready && !flush_i;
  assign w_load     = w_accept && w_legal;
  assign w_trap     = w_accept && !w_legal;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  // Next state: TRAP is terminal until reset.
  always_comb begin
    w_next = r_state;
    if (r_state == RUN && w_trap) w_next = TRAP;
  end

  // ID/EX slot: flush forces a bubble even when EX is not consuming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= IMM_I;
      r_instr <= '0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (flush_i || w_adv) begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl;
        r_imm   <= w_imm;
        r_instr <= if_instr;
        r_pc    <= if_pc;
        r_rd    <= if_instr[11:7];
        r_rs1   <= w_rs1;
        r_rs2   <= w_rs2;
      end else begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_imm   <= IMM_I;
      end
    end
  end

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_adv && !flush_i && w_hazard && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign if_ready     = w_if_ready;
  assign id_valid     = r_valid;
  assign id_instr     = r_instr;
  assign id_pc        = r_pc;
  assign imm_sel      = r_imm;
  assign id_rd        = r_rd;
  assign id_rs1       = r_rs1;
  assign id_rs2       = r_rs2;
  assign id_is_load   = r_ctrl.is_load;
  assign id_mem_write = r_ctrl.mem_write;
  assign id_reg_write = r_ctrl.reg_write;
  assign id_branch    = r_ctrl.branch;
  assign id_jump      = r_ctrl.jump;
  assign id_illegal   = (r_state == TRAP);
  assign stall_cnt    = r_cnt;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl with hand-computed expectations.
module tb_decode_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] LUI_X5   = 32'h123452B7;
  localparam logic [31:0] LW_X6    = 32'h0000A303;
  localparam logic [31:0] ADD_RS1  = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] ADD_RS2  = 32'h006103B3; // add x7,x2,x6
  localparam logic [31:0] LW_X0    = 32'h0000A003;
  localparam logic [31:0] ADD_X0   = 32'h002003B3; // add x7,x0,x2
  localparam logic [31:0] SW       = 32'h0020A023;
  localparam logic [31:0] ILL      = 32'h0000007F;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_valid;
  logic [XLEN-1:0]  if_instr, if_pc;
  logic             if_ready;
  logic             flush_i, ex_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_instr, id_pc;
  logic [2:0]       imm_sel;
  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic             id_is_load, id_mem_write, id_reg_write, id_branch, id_jump;
  logic             id_illegal;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  decode_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .flush_i(flush_i), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .imm_sel(imm_sel),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_is_load(id_is_load),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_illegal(id_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic er, input logic fl);
    if_valid = v;
    if_instr = ins;
    if_pc    = ins ^ 32'h1000_0000;
    ex_ready = er;
    flush_i  = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  typedef struct { logic [31:0] ins; logic [2:0] imm; logic [4:0] ctl; } vec_t;
  vec_t tbl[5];
  logic [3:0] exp_cnt;

  initial begin
    // {is_load, mem_write, reg_write, branch, jump}
    tbl[0] = '{32'h00208063, 3'b010, 5'b00010}; // beq x1,x2
    tbl[1] = '{32'h000000EF, 3'b001, 5'b00101}; // jal x1
    tbl[2] = '{32'h000100E7, 3'b100, 5'b00101}; // jalr x1,0(x2)
    tbl[3] = '{32'h00000197, 3'b011, 5'b00100}; // auipc x3
    tbl[4] = '{32'h00108213, 3'b100, 5'b00100}; // addi x4,x1,1

    rst_n = 1'b0;
    drive(1'b0, NOP, 1'b1, 1'b0);
    mid();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_imm", 32'(imm_sel), 32'd4);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_rd", 32'(id_rd), 32'd0);
    chk("rst_illegal", 32'(id_illegal), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_regwr", 32'(id_reg_write), 32'd0);
    tick();
    rst_n = 1'b1;

    // lui x5
    drive(1'b1, LUI_X5, 1'b1, 1'b0);
    mid(); chk("lui_rdy", 32'(if_ready), 32'd1);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0);
    mid();
    chk("lui_valid", 32'(id_valid), 32'd1);
    chk("lui_imm", 32'(imm_sel), 32'd3);
    chk("lui_rd", 32'(id_rd), 32'd5);
    chk("lui_wr", 32'(id_reg_write), 32'd1);
    chk("lui_instr", id_instr, LUI_X5);
    chk("lui_pc", id_pc, LUI_X5 ^ 32'h1000_0000);
    chk("lui_cnt", 32'(stall_cnt), 32'd0);

    // load-use: lw x6 ; add x7,x6,x2
    tick();
    drive(1'b1, LW_X6, 1'b1, 1'b0);
    tick();
    drive(1'b1, ADD_RS1, 1'b1, 1'b0);
    mid();
    chk("lu_stall_rdy", 32'(if_ready), 32'd0);
    chk("lu_lw_load", 32'(id_is_load), 32'd1);
    tick();
    mid();
    chk("lu_bubble", 32'(id_valid), 32'd0);
    chk("lu_bubble_imm", 32'(imm_sel), 32'd4);
    chk("lu_rdy_again", 32'(if_ready), 32'd1);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0);
    mid();
    chk("lu_add_valid", 32'(id_valid), 32'd1);
    chk("lu_add_instr", id_instr, ADD_RS1);
    chk("lu_add_rs1", 32'(id_rs1), 32'd6);

    // lw x0 ; add x7,x0,x2: no hazard
    tick();
    drive(1'b1, LW_X0, 1'b1, 1'b0);
    tick();
    drive(1'b1, ADD_X0, 1'b1, 1'b0);
    mid();
    chk("x0_rdy", 32'(if_ready), 32'd1);
    chk("x0_lw_wr", 32'(id_reg_write), 32'd0);
    chk("x0_lw_load", 32'(id_is_load), 32'd1);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0);
    mid();
    chk("x0_add_instr", id_instr, ADD_X0);
    chk("x0_cnt", 32'(stall_cnt), 32'd1);

    // opcode table
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, tbl[i].ins, 1'b1, 1'b0);
      tick();
      drive(1'b0, NOP, 1'b1, 1'b0);
      mid();
      chk($sformatf("tbl%0d_imm", i), 32'(imm_sel), 32'(tbl[i].imm));
      chk($sformatf("tbl%0d_ctl", i),
          32'({id_is_load, id_mem_write, id_reg_write, id_branch, id_jump}), 32'(tbl[i].ctl));
    end

    // sw held under back-pressure, then flushed without ex_ready
    tick();
    drive(1'b1, SW, 1'b1, 1'b0);
    tick();
    drive(1'b1, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("hold%0d_valid", i), 32'(id_valid), 32'd1);
      chk($sformatf("hold%0d_imm", i), 32'(imm_sel), 32'd0);
      chk($sformatf("hold%0d_rdy", i), 32'(if_ready), 32'd0);
      chk($sformatf("hold%0d_instr", i), id_instr, SW);
      chk($sformatf("hold%0d_mw", i), 32'(id_mem_write), 32'd1);
      tick();
    end
    drive(1'b0, NOP, 1'b0, 1'b1);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0);
    mid();
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_mw", 32'(id_mem_write), 32'd0);
    chk("flush_imm", 32'(imm_sel), 32'd4);

    // illegal word alongside a flush: discarded, no trap
    tick();
    drive(1'b1, ILL, 1'b1, 1'b1);
    tick();
    drive(1'b1, NOP, 1'b1, 1'b0);
    mid();
    chk("flill_illegal", 32'(id_illegal), 32'd0);
    chk("flill_valid", 32'(id_valid), 32'd0);
    chk("flill_rdy", 32'(if_ready), 32'd1);

    // illegal accept -> TRAP
    tick();
    drive(1'b1, ILL, 1'b1, 1'b0);
    tick();
    drive(1'b1, NOP, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("trap%0d_ill", i), 32'(id_illegal), 32'd1);
      chk($sformatf("trap%0d_rdy", i), 32'(if_ready), 32'd0);
      chk($sformatf("trap%0d_valid", i), 32'(id_valid), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    mid();
    chk("rst2_ill", 32'(id_illegal), 32'd0);
    chk("rst2_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    mid();
    chk("rst2_rdy", 32'(if_ready), 32'd1);

    // saturation: 2^CNT_W+3 load-use pairs, alternating rs1/rs2 dependency
    exp_cnt = 4'd0;
    for (int p = 0; p < (1 << CNT_W) + 3; p++) begin
      tick();
      drive(1'b1, LW_X6, 1'b1, 1'b0);
      tick();
      drive(1'b1, (p % 2 == 0) ? ADD_RS1 : ADD_RS2, 1'b1, 1'b0);
      mid();
      chk($sformatf("sat%0d_stall", p), 32'(if_ready), 32'd0);
      tick();
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      mid();
      chk($sformatf("sat%0d_cnt", p), 32'(stall_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(stall_cnt), 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
